// File: rtl/dcu.sv
// rtl/dcu.sv - nibble-serial decipher unit (inverse toy-SPN, one round per clock)
//
// Collects a 16-bit ciphertext block and a 16-bit key as four nibbles each
// (most-significant first), decrypts with ROUNDS inverse rounds, and streams
// the plaintext out as four nibbles (most-significant first).
//
// Optional feature macro: DCU_BUSY_EN (adds the busy output).
//
// Ports:
//   clk       in   1  rising-edge clock
//   reset     in   1  synchronous active-high reset
//   in_valid  in   1  data_in/key nibble present
//   data_in   in   4  ciphertext nibble, MS first
//   key       in   4  key nibble, MS first
//   in_ready  out  1  high in LOAD (and not in reset); transfer on in_valid & in_ready
//   out_valid out  1  plaintext nibble valid (registered)
//   data_out  out  4  plaintext nibble, MS first (registered)
//   out_last  out  1  high with the 4th output nibble (registered)
//   busy      out  1  only with DCU_BUSY_EN: high in WHITEN, ROUND, OUT
module dcu #(
  parameter int ROUNDS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] data_in,
  input  logic [3:0] key,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] data_out,
  output logic       out_last
`ifdef DCU_BUSY_EN
  ,
  output logic       busy
`endif
);

  localparam logic [3:0] NUM_ROUNDS = 4'(ROUNDS);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WHITEN = 2'd1,
    ROUND  = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [1:0]  cnt, cnt_d;          // load transfers, then output nibbles
  logic [3:0]  rnd, rnd_d;          // current round index r
  logic [15:0] c_reg, c_reg_d;
  logic [15:0] k_reg, k_reg_d;
  logic [15:0] s, s_d;
  logic [3:0]  data_out_d;
  logic        out_valid_d;
  logic        out_last_d;
  logic [15:0] round_out;

  function automatic logic [3:0] sinv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // K_r = rotl16(K, 4*(r mod 4)) with r folded into the low nibble.
  function automatic logic [15:0] round_key(input logic [15:0] k, input logic [3:0] r);
    logic [15:0] rk;
    case (r[1:0])
      2'd0:    rk = k;
      2'd1:    rk = {k[11:0], k[15:12]};
      2'd2:    rk = {k[7:0], k[15:8]};
      default: rk = {k[3:0], k[15:4]};
    endcase
    return rk ^ {12'h000, r};
  endfunction

  function automatic logic [15:0] inv_round(input logic [15:0] st, input logic [15:0] k,
                                            input logic [3:0] r);
    logic [15:0] t;
    t = {st[3:0], st[15:4]};
    t = {sinv(t[15:12]), sinv(t[11:8]), sinv(t[7:4]), sinv(t[3:0])};
    return t ^ round_key(k, r - 4'd1);
  endfunction

  // Gated with reset so nothing looks acceptable while reset is held.
  assign in_ready = (state == LOAD) && !reset;
`ifdef DCU_BUSY_EN
  assign busy = (state != LOAD) && !reset;
`endif

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    rnd_d       = rnd;
    c_reg_d     = c_reg;
    k_reg_d     = k_reg;
    s_d         = s;
    data_out_d  = 4'h0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    round_out   = inv_round(s, k_reg, rnd);
    case (state)
      LOAD: begin
        if (in_valid) begin
          c_reg_d = {c_reg[11:0], data_in};
          k_reg_d = {k_reg[11:0], key};
          cnt_d   = cnt + 2'd1;
          if (cnt == 2'd3) state_d = WHITEN;
        end
      end
      WHITEN: begin
        s_d     = c_reg ^ round_key(k_reg, NUM_ROUNDS);
        rnd_d   = NUM_ROUNDS;
        state_d = ROUND;
      end
      ROUND: begin
        rnd_d = rnd - 4'd1;
        if (rnd == 4'd1) begin
          // Last round: present the first nibble immediately so out_valid
          // is registered and lines up with entry into OUT.
          state_d     = OUT;
          s_d         = {round_out[11:0], 4'h0};
          data_out_d  = round_out[15:12];
          out_valid_d = 1'b1;
          cnt_d       = 2'd0;
        end else begin
          s_d = round_out;
        end
      end
      OUT: begin
        cnt_d = cnt + 2'd1;
        if (cnt == 2'd3) begin
          state_d = LOAD;
        end else begin
          out_valid_d = 1'b1;
          data_out_d  = s[15:12];
          s_d         = {s[11:0], 4'h0};
          out_last_d  = (cnt == 2'd2);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      cnt       <= 2'd0;
      rnd       <= 4'd0;
      c_reg     <= 16'h0000;
      k_reg     <= 16'h0000;
      s         <= 16'h0000;
      data_out  <= 4'h0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      rnd       <= rnd_d;
      c_reg     <= c_reg_d;
      k_reg     <= k_reg_d;
      s         <= s_d;
      data_out  <= data_out_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_dcu.sv
// tb/tb_dcu.sv - self-checking bench for dcu (ROUNDS=4 main instance, ROUNDS=1 side instance)
module tb_dcu;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] data_in;
  logic [3:0] key;
  logic       in_ready, out_valid, out_last;
  logic [3:0] data_out;
  logic       r1_in_ready, r1_out_valid, r1_out_last;
  logic [3:0] r1_data_out;
`ifdef DCU_BUSY_EN
  logic       busy, r1_busy;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dcu #(.ROUNDS(R)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in), .key(key),
    .in_ready(in_ready), .out_valid(out_valid), .data_out(data_out), .out_last(out_last)
`ifdef DCU_BUSY_EN
    , .busy(busy)
`endif
  );

  dcu #(.ROUNDS(1)) dut_r1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in), .key(key),
    .in_ready(r1_in_ready), .out_valid(r1_out_valid), .data_out(r1_data_out),
    .out_last(r1_out_last)
`ifdef DCU_BUSY_EN
    , .busy(r1_busy)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Forward (ccu) cipher model.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [15:0] model_rk(input logic [15:0] k, input int r);
    logic [31:0] t;
    t = {k, k} << (4 * (r % 4));
    return t[31:16] ^ 16'(r);
  endfunction

  function automatic logic [15:0] encrypt(input logic [15:0] p, input logic [15:0] k);
    logic [15:0] st;
    st = p ^ model_rk(k, 0);
    for (int r = 1; r <= R; r++) begin
      st = {sbox(st[15:12]), sbox(st[11:8]), sbox(st[7:4]), sbox(st[3:0])};
      st = {st[11:0], st[15:12]} ^ model_rk(k, r);
    end
    return st;
  endfunction

  task automatic send_block(input logic [15:0] c, input logic [15:0] k, input bit gaps);
    logic [15:0] cs, ks;
    int w;
    cs = c;
    ks = k;
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          data_in = 4'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      data_in  = cs[15:12];
      key      = ks[15:12];
      cs = cs << 4;
      ks = ks << 4;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) check("handshake timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // Cycle 1 is the cycle after the 4th transfer.
  task automatic collect(input logic [15:0] exp_p, input bit poke);
    logic [15:0] got;
    int n, first, last_at;
    got = 16'h0;
    n = 0;
    first = -1;
    last_at = -1;
    for (int cyc = 1; cyc <= R + 6; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = cyc;
        got = {got[11:0], data_out};
        n++;
        if (out_last) last_at = n;
      end
`ifdef DCU_BUSY_EN
      if (cyc == 1) check("busy rises", 32'(busy), 32'd1);
      if (cyc == R + 6) check("busy falls", 32'(busy), 32'd0);
`endif
      if (cyc == R + 5) check("in_ready low in OUT", 32'(in_ready), 32'd0);
      if (cyc == R + 6) check("in_ready back", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = (poke && (cyc + 1 <= R + 5)) ? 1'($urandom_range(0, 1)) : 1'b0;
      data_in  = 4'($urandom);
      key      = 4'($urandom);
    end
    check("first out cycle", 32'(first), 32'(R + 2));
    check("nibble count", 32'(n), 32'd4);
    check("plaintext", 32'(got), 32'(exp_p));
    check("out_last position", 32'(last_at), 32'd4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p, k, c, got;
    int first, cnt;

    // Reset held with in_valid asserted.
    reset = 1'b1; in_valid = 1'b1; data_in = 4'hF; key = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("reset outputs", {out_valid, out_last, data_out, in_ready}, 32'd0);
`ifdef DCU_BUSY_EN
        check("reset busy", 32'(busy), 32'd0);
`endif
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("in_ready after reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Known vector, ROUNDS=4.
    send_block(16'h0000, 16'h0000, 1'b0);
    collect(16'hABA1, 1'b0);

    // Round trip against the forward model.
    for (int t = 0; t < 200; t++) begin
      p = 16'($urandom);
      k = 16'($urandom);
      c = encrypt(p, k);
      send_block(c, k, 1'b1);
      collect(p, 1'b1);
    end

    // Reset during OUT after the 2nd nibble.
    p = 16'h1234; k = 16'hBEEF;
    send_block(encrypt(p, k), k, 1'b0);
    for (int cyc = 1; cyc <= R + 3; cyc++) begin
      @(negedge clk);
      if (cyc == R + 3) check("out_valid before mid reset", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("out_valid drops after reset", 32'(out_valid), 32'd0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("no output after reset", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    p = 16'hC0DE; k = 16'h5A5A;
    send_block(encrypt(p, k), k, 1'b0);
    collect(p, 1'b0);

    // ROUNDS=1 instance, both instances restarted together.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    send_block(16'h0000, 16'h0000, 1'b0);
    got = 16'h0; first = -1; cnt = 0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (r1_out_valid) begin
        if (first < 0) first = cyc;
        got = {got[11:0], r1_data_out};
        cnt++;
        if (cnt == 4) check("r1 out_last", 32'(r1_out_last), 32'd1);
      end
      if (cyc == 7) check("r1 in_ready back", 32'(r1_in_ready), 32'd1);
    end
    check("r1 first out cycle", 32'(first), 32'd3);
    check("r1 plaintext", 32'(got), 32'hE555);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
